// File: rtl/inst_prefetch_buffer.sv
// Instruction-fetch front end: fetches words over a req/ack memory handshake into a small FIFO
// of {pc, instruction} pairs that feeds the IF/ID register; redirect flushes and restarts fetch.
module inst_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         mem_req,
    output logic [31:0]                  mem_addr,
    input  logic                         mem_ack,
    input  logic [31:0]                  mem_rdata,
    input  logic                         redirect,
    input  logic [31:0]                  redirect_pc,
    input  logic                         consume,
    output logic                         inst_valid,
    output logic [31:0]                  inst,
    output logic [31:0]                  inst_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]    state, state_next;
    logic [31:0]   fetch_pc, fetch_pc_next;
    logic [31:0]   tgt, tgt_next;
    logic [31:0]   redirect_tgt;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count_next;
    logic          push, pop;

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];

    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next    = state;
        fetch_pc_next = fetch_pc;
        tgt_next      = tgt;
        push          = (state == S_WAIT) && mem_ack && !redirect;
        pop           = consume && inst_valid && !redirect;
        count_next    = redirect ? '0 : count + CW'(push) - CW'(pop);

        case (state)
            S_IDLE: begin
                if (redirect)
                    fetch_pc_next = redirect_tgt;
                else if (count < FULL)
                    state_next = S_WAIT;
            end
            S_WAIT: begin
                if (mem_ack) begin
                    if (redirect) begin
                        fetch_pc_next = redirect_tgt;
                    end else begin
                        fetch_pc_next = fetch_pc + 32'd4;
                        if (count_next >= FULL)
                            state_next = S_IDLE;
                    end
                end else if (redirect) begin
                    // The in-flight request must finish at its old address before we can move on.
                    tgt_next   = redirect_tgt;
                    state_next = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (mem_ack) begin
                    fetch_pc_next = redirect ? redirect_tgt : tgt;
                    state_next    = S_WAIT;
                end else if (redirect) begin
                    tgt_next = redirect_tgt;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            tgt      <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            tgt      <= tgt_next;
            count    <= count_next;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; count/inst_valid gate every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            data_mem[wr_ptr] <= mem_rdata;
        end
    end

    assign mem_req    = (state != S_IDLE);
    assign mem_addr   = fetch_pc;
    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? data_mem[rd_ptr] : 32'h0;
    assign inst_pc    = inst_valid ? pc_mem[rd_ptr]   : 32'h0;

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Bench for inst_prefetch_buffer: directed scenarios plus randomized traffic, all checked every
// cycle against a transaction-level queue model of the fetch buffer.
module tb_inst_prefetch_buffer;

    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        consume;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [2:0]  count;

    logic        mem_req_w;
    logic [31:0] mem_addr_w;
    logic [31:0] mem_rdata_w;
    logic        ack_w = 1'b1;
    logic        redirect_w = 1'b0;
    logic [31:0] redirect_pc_w = 32'h0;
    logic        consume_w;
    logic        inst_valid_w;
    logic [31:0] inst_w;
    logic [31:0] inst_pc_w;
    logic [2:0]  count_w;

    // Instruction memory contents are a fixed function of the address.
    assign mem_rdata   = mem_addr ^ KEY;
    assign mem_rdata_w = mem_addr_w ^ KEY;

    inst_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .consume(consume),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .count(count)
    );

    inst_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst(rst),
        .mem_req(mem_req_w), .mem_addr(mem_addr_w), .mem_ack(ack_w), .mem_rdata(mem_rdata_w),
        .redirect(redirect_w), .redirect_pc(redirect_pc_w), .consume(consume_w),
        .inst_valid(inst_valid_w), .inst(inst_w), .inst_pc(inst_pc_w), .count(count_w)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: the queue holds what IF/ID should see; next_pc is the address the
    // next useful fetch must carry; stale marks a request made obsolete by a redirect.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    entry_t      q[$];
    logic [31:0] next_pc;
    bit          stale;
    bit          model_live = 0;
    bit          req_at_edge;
    bit          hold_pending;
    logic [31:0] hold_addr;
    int          n_push = 0;

    always @(posedge clk) begin
        if (!rst) begin
            q.delete();
            next_pc      = 32'h0;
            stale        = 0;
            model_live   = 1;
            req_at_edge  = 0;
            hold_pending = 0;
        end else if (model_live) begin
            req_at_edge  = mem_req;
            hold_pending = mem_req && !mem_ack;
            hold_addr    = mem_addr;
            if (consume && q.size() > 0 && !redirect)
                void'(q.pop_front());
            if (mem_req && mem_ack) begin
                if (!stale && !redirect) begin
                    q.push_back('{pc: next_pc, data: next_pc ^ KEY});
                    next_pc = next_pc + 32'd4;
                    n_push++;
                end
                stale = 0;
            end else if (mem_req && redirect) begin
                stale = 1;
            end
            if (redirect) begin
                q.delete();
                next_pc = redirect_pc & 32'hFFFF_FFFC;
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("count", {29'b0, count}, q.size());
            check("inst_valid", {31'b0, inst_valid}, {31'b0, q.size() != 0});
            if (q.size() != 0) begin
                check("inst_pc", inst_pc, q[0].pc);
                check("inst", inst, q[0].data);
            end else begin
                check("inst_pc_empty", inst_pc, 32'h0);
                check("inst_empty", inst, 32'h0);
            end
            if (mem_req && !stale)
                check("mem_addr", mem_addr, next_pc);
            if (hold_pending) begin
                check("req_held", {31'b0, mem_req}, 32'd1);
                check("addr_held", mem_addr, hold_addr);
            end
            if (mem_req && !req_at_edge)
                check("req_rise_room", {31'b0, q.size() < DEPTH}, 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; mem_ack = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; consume = 1'b0;
        consume_w = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_count", {29'b0, count}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        rst = 1'b1;
        tick();
        check("first_req", {31'b0, mem_req}, 32'd1);
        check("first_addr", mem_addr, 32'h0);

        // Fill with a constant ack
        mem_ack = 1'b1;
        repeat (4) tick();
        check("fill_count", {29'b0, count}, 32'd4);
        check("fill_req_low", {31'b0, mem_req}, 32'd0);
        check("fill_inst", inst, 32'hA5A5_0000);
        check("fill_inst_pc", inst_pc, 32'h0);
        tick();
        check("full_stays_idle", {31'b0, mem_req}, 32'd0);

        // Pop from full, then push+pop together
        consume = 1'b1;
        tick();
        consume = 1'b0;
        check("pop_count", {29'b0, count}, 32'd3);
        check("pop_inst_pc", inst_pc, 32'h4);
        tick();
        check("rereq", {31'b0, mem_req}, 32'd1);
        check("rereq_addr", mem_addr, 32'h10);
        consume = 1'b1;
        tick();
        consume = 1'b0;
        mem_ack = 1'b0;
        check("pushpop_count", {29'b0, count}, 32'd3);
        check("pushpop_inst_pc", inst_pc, 32'h8);

        // Redirect while a request waits
        tick();
        redirect = 1'b1; redirect_pc = 32'h43;
        tick();
        redirect = 1'b0;
        check("redir_flush", {29'b0, count}, 32'd0);
        check("redir_hold_req", {31'b0, mem_req}, 32'd1);
        check("redir_hold_addr", mem_addr, 32'h14);
        tick();
        check("redir_hold_addr2", mem_addr, 32'h14);
        mem_ack = 1'b1;
        tick();
        check("discard_count", {29'b0, count}, 32'd0);
        check("discard_next_addr", mem_addr, 32'h40);
        tick();
        check("redir_first_pc", inst_pc, 32'h40);
        check("redir_first_inst", inst, 32'hA5A5_0040);

        // Redirect + ack + consume together with two entries held
        tick();
        check("two_held", {29'b0, count}, 32'd2);
        redirect = 1'b1; redirect_pc = 32'h200; consume = 1'b1;
        tick();
        redirect = 1'b0; consume = 1'b0;
        check("rac_count", {29'b0, count}, 32'd0);
        check("rac_valid", {31'b0, inst_valid}, 32'd0);
        check("rac_req", {31'b0, mem_req}, 32'd1);
        check("rac_addr", mem_addr, 32'h200);
        tick();
        mem_ack = 1'b0;
        check("rac_first_pc", inst_pc, 32'h200);

        // Randomized traffic, including occasional resets
        for (int i = 0; i < 3000; i++) begin
            mem_ack     = ($urandom_range(0, 99) < 50);
            consume     = ($urandom_range(0, 99) < 40);
            redirect    = ($urandom_range(0, 99) < 5);
            redirect_pc = $urandom();
            rst         = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
            tick();
        end
        mem_ack = 1'b0; consume = 1'b0; redirect = 1'b0; rst = 1'b1;
        check("push_progress", {31'b0, n_push > 300}, 32'd1);

        // Address wrap on the second instance
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 20 && count_w != 3'd4; i++) tick();
        check("wrap_fill", {29'b0, count_w}, 32'd4);
        check("wrap_pc0", inst_pc_w, 32'hFFFF_FFF8);
        consume_w = 1'b1;
        tick();
        check("wrap_pc1", inst_pc_w, 32'hFFFF_FFFC);
        tick();
        check("wrap_pc2", inst_pc_w, 32'h0000_0000);
        tick();
        check("wrap_pc3", inst_pc_w, 32'h0000_0004);
        consume_w = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
